// File: rtl/mem_arbiter.sv
// Shares the memory port between I-fetch and D-side requesters,
// tracks load tag ownership and routes tagged responses back.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4,
    localparam int TAG_W       = $clog2(NUM_TAGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic              ic_rsp_valid,
    output logic [DATA_W-1:0] ic_rsp_data,
    input  logic              dc_req,
    input  logic              dc_store,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic              dc_rsp_valid,
    output logic [DATA_W-1:0] dc_rsp_data,
    input  logic              squash_ic,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_transaction_tag,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_data_tag,
    output logic              tag_error
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [SW-1:0]       starve_cnt;
    logic [NUM_TAGS-1:0] tag_valid;
    logic [NUM_TAGS-1:0] tag_owner_ic;
    logic [NUM_TAGS-1:0] tag_squashed;
    logic [NUM_TAGS-1:0] valid_next;
    logic [NUM_TAGS-1:0] owner_next;
    logic [NUM_TAGS-1:0] squashed_next;

    logic sel_ic;
    logic sel_dc;
    logic accepted;
    logic load_accept;
    logic rsp_tag_nz;
    logic rsp_hit;

    // Every combinational output is qualified by reset so the port is quiet in reset.
    assign sel_ic = reset && ic_req && (!dc_req || starve_cnt == LIMIT);
    assign sel_dc = reset && dc_req && !sel_ic;

    assign accepted    = mem2proc_transaction_tag != '0;
    assign ic_ack      = sel_ic && accepted;
    assign dc_ack      = sel_dc && accepted;
    assign load_accept = ic_ack || (dc_ack && !dc_store);

    always_comb begin
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (sel_ic) begin
            proc2mem_command = CMD_LOAD;
            proc2mem_addr    = ic_addr;
        end else if (sel_dc) begin
            proc2mem_command = dc_store ? CMD_STORE : CMD_LOAD;
            proc2mem_addr    = dc_addr;
            if (dc_store) begin
                proc2mem_data = dc_wdata;
            end
        end
    end

    assign rsp_tag_nz = reset && mem2proc_data_tag != '0;
    assign rsp_hit    = rsp_tag_nz && tag_valid[mem2proc_data_tag];

    assign ic_rsp_valid = rsp_hit && tag_owner_ic[mem2proc_data_tag]
                          && !tag_squashed[mem2proc_data_tag];
    assign dc_rsp_valid = rsp_hit && !tag_owner_ic[mem2proc_data_tag];
    assign ic_rsp_data  = ic_rsp_valid ? mem2proc_data : '0;
    assign dc_rsp_data  = dc_rsp_valid ? mem2proc_data : '0;

    // Order matters: free the responding tag, squash, then record the new load.
    always_comb begin
        valid_next    = tag_valid;
        owner_next    = tag_owner_ic;
        squashed_next = tag_squashed;
        if (rsp_tag_nz) begin
            valid_next[mem2proc_data_tag]    = 1'b0;
            squashed_next[mem2proc_data_tag] = 1'b0;
        end
        if (squash_ic) begin
            squashed_next = squashed_next | (valid_next & owner_next);
        end
        if (load_accept) begin
            valid_next[mem2proc_transaction_tag]    = 1'b1;
            owner_next[mem2proc_transaction_tag]    = sel_ic;
            squashed_next[mem2proc_transaction_tag] = sel_ic && squash_ic;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid    <= '0;
            tag_owner_ic <= '0;
            tag_squashed <= '0;
            starve_cnt   <= '0;
            tag_error    <= 1'b0;
        end else begin
            tag_valid    <= valid_next;
            tag_owner_ic <= owner_next;
            tag_squashed <= squashed_next;
            if (rsp_tag_nz && !tag_valid[mem2proc_data_tag]) begin
                tag_error <= 1'b1;
            end
            if (!ic_req || ic_ack) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: arbitration, starvation,
// rejection, routing, squash, tag reuse, stores and reset mid-traffic.
module tb_mem_arbiter;

    localparam logic [31:0] IA = 32'h1000_0040;
    localparam logic [31:0] DA = 32'h2000_0080;
    localparam logic [63:0] WD = 64'hDEAD_BEEF_0123_4567;

    logic        clock;
    logic        reset;
    logic        ic_req;
    logic        ic_ack;
    logic        ic_rsp_valid;
    logic [63:0] ic_rsp_data;
    logic        dc_req;
    logic        dc_store;
    logic        dc_ack;
    logic        dc_rsp_valid;
    logic [63:0] dc_rsp_data;
    logic        squash_ic;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  ttag;
    logic [63:0] mdata;
    logic [3:0]  dtag;
    logic        tag_error;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .clock                    (clock),
        .reset                    (reset),
        .ic_req                   (ic_req),
        .ic_addr                  (IA),
        .ic_ack                   (ic_ack),
        .ic_rsp_valid             (ic_rsp_valid),
        .ic_rsp_data              (ic_rsp_data),
        .dc_req                   (dc_req),
        .dc_store                 (dc_store),
        .dc_addr                  (DA),
        .dc_wdata                 (WD),
        .dc_ack                   (dc_ack),
        .dc_rsp_valid             (dc_rsp_valid),
        .dc_rsp_data              (dc_rsp_data),
        .squash_ic                (squash_ic),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (ttag),
        .mem2proc_data            (mdata),
        .mem2proc_data_tag        (dtag),
        .tag_error                (tag_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        ic;
        logic        dc;
        logic        st;
        logic        sq;
        logic [3:0]  tt;
        logic [3:0]  dt;
        logic [15:0] md;
        logic        eia;
        logic        eda;
        logic [1:0]  sel;
        logic        eirv;
        logic        edrv;
        logic        eterr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic ic, input logic dc, input logic st, input logic sq,
        input int tt, input int dt, input int md,
        input logic eia, input logic eda, input int sel,
        input logic eirv, input logic edrv, input logic eterr);
        vec_t v;
        v.ic = ic; v.dc = dc; v.st = st; v.sq = sq;
        v.tt = 4'(tt); v.dt = 4'(dt); v.md = 16'(md);
        v.eia = eia; v.eda = eda; v.sel = 2'(sel);
        v.eirv = eirv; v.edrv = edrv; v.eterr = eterr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ic, input logic dc, input logic st,
                         input logic sq, input logic [3:0] tt,
                         input logic [3:0] dt, input logic [63:0] md);
        ic_req = ic; dc_req = dc; dc_store = st; squash_ic = sq;
        ttag = tt; dtag = dt; mdata = md;
    endtask

    task automatic chk_quiet(input string p, input logic eterr);
        chk({p, " ic_ack"}, 64'(ic_ack), 64'd0);
        chk({p, " dc_ack"}, 64'(dc_ack), 64'd0);
        chk({p, " cmd"}, 64'(proc2mem_command), 64'd0);
        chk({p, " addr"}, 64'(proc2mem_addr), 64'd0);
        chk({p, " data"}, proc2mem_data, 64'd0);
        chk({p, " ic_rv"}, 64'(ic_rsp_valid), 64'd0);
        chk({p, " ic_rd"}, ic_rsp_data, 64'd0);
        chk({p, " dc_rv"}, 64'(dc_rsp_valid), 64'd0);
        chk({p, " dc_rd"}, dc_rsp_data, 64'd0);
        chk({p, " tag_error"}, 64'(tag_error), 64'(eterr));
    endtask

    initial begin
        logic [1:0]  ecmd;
        logic [31:0] eaddr;
        logic [63:0] edata;
        string p;

        // Starvation: D wins four cycles, then I is forced through.
        vq.push_back(mk(1,1,0,0, 1,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(1,1,0,0, 2,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(1,1,0,0, 3,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(1,1,0,0, 4,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(1,1,0,0, 5,0,0,      1,0,1,0,0,0));
        vq.push_back(mk(1,1,0,0, 6,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,      0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,5,'hBB,   0,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0, 0,1,'h11,   0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,2,'h12,   0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,3,'h13,   0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,4,'h14,   0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,6,'h16,   0,0,0,0,1,0));
        // Rejection then acceptance on tag 5.
        vq.push_back(mk(0,1,0,0, 0,0,0,      0,0,2,0,0,0));
        vq.push_back(mk(0,1,0,0, 0,0,0,      0,0,2,0,0,0));
        vq.push_back(mk(0,1,0,0, 5,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,5,'h55,   0,0,0,0,1,0));
        // Routing.
        vq.push_back(mk(1,0,0,0, 3,0,0,      1,0,1,0,0,0));
        vq.push_back(mk(0,1,0,0, 7,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,7,'hAAAA, 0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,3,'hBBBB, 0,0,0,1,0,0));
        // Squash.
        vq.push_back(mk(1,0,0,0, 2,0,0,      1,0,1,0,0,0));
        vq.push_back(mk(1,0,0,0, 4,0,0,      1,0,1,0,0,0));
        vq.push_back(mk(0,0,0,1, 0,0,0,      0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,2,'h22,   0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,4,'h44,   0,0,0,0,0,0));
        vq.push_back(mk(1,0,0,0, 6,0,0,      1,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,6,'h66,   0,0,0,1,0,0));
        vq.push_back(mk(1,0,0,1, 8,0,0,      1,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,8,'h88,   0,0,0,0,0,0));
        vq.push_back(mk(1,0,0,0, 10,0,0,     1,0,1,0,0,0));
        vq.push_back(mk(0,0,0,1, 0,10,'hA0,  0,0,0,1,0,0));
        vq.push_back(mk(0,1,0,0, 11,0,0,     0,1,2,0,0,0));
        vq.push_back(mk(0,0,0,1, 0,0,0,      0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,11,'hB1,  0,0,0,0,1,0));
        // Tag reuse in the same cycle.
        vq.push_back(mk(0,1,0,0, 5,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(0,1,0,0, 5,5,'h51,   0,1,2,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,5,'h52,   0,0,0,0,1,0));
        vq.push_back(mk(1,0,0,0, 12,0,0,     1,0,1,0,0,0));
        vq.push_back(mk(0,1,0,0, 12,12,'hC1, 0,1,2,1,0,0));
        vq.push_back(mk(0,0,0,0, 0,12,'hC2,  0,0,0,0,1,0));
        // Stores are not recorded: a response on their tag is an error.
        vq.push_back(mk(0,1,1,0, 9,0,0,      0,1,2,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,9,'h99,   0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,      0,0,0,0,0,1));
        // Rejected cycles also count toward starvation.
        vq.push_back(mk(1,1,0,0, 0,0,0,      0,0,2,0,0,1));
        vq.push_back(mk(1,1,0,0, 0,0,0,      0,0,2,0,0,1));
        vq.push_back(mk(1,1,0,0, 0,0,0,      0,0,2,0,0,1));
        vq.push_back(mk(1,1,0,0, 0,0,0,      0,0,2,0,0,1));
        vq.push_back(mk(1,1,0,0, 0,0,0,      0,0,1,0,0,1));
        vq.push_back(mk(1,1,0,0, 13,0,0,     1,0,1,0,0,1));
        vq.push_back(mk(0,0,0,0, 0,13,'hD3,  0,0,0,1,0,1));

        // Reset state with live-looking inputs.
        reset = 1'b0;
        drive(1, 1, 1, 0, 4'd3, 4'd2, 64'h77);
        #2;
        chk_quiet("reset0", 1'b0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        foreach (vq[i]) begin
            @(negedge clock);
            drive(vq[i].ic, vq[i].dc, vq[i].st, vq[i].sq,
                  vq[i].tt, vq[i].dt, 64'(vq[i].md));
            #2;
            ecmd  = 2'd0;
            eaddr = '0;
            edata = '0;
            if (vq[i].sel == 2'd1) begin
                ecmd  = 2'd1;
                eaddr = IA;
            end else if (vq[i].sel == 2'd2) begin
                ecmd  = vq[i].st ? 2'd2 : 2'd1;
                eaddr = DA;
                edata = vq[i].st ? WD : 64'd0;
            end
            p = $sformatf("step%0d", i);
            chk({p, " ic_ack"}, 64'(ic_ack), 64'(vq[i].eia));
            chk({p, " dc_ack"}, 64'(dc_ack), 64'(vq[i].eda));
            chk({p, " cmd"}, 64'(proc2mem_command), 64'(ecmd));
            chk({p, " addr"}, 64'(proc2mem_addr), 64'(eaddr));
            chk({p, " data"}, proc2mem_data, edata);
            chk({p, " ic_rv"}, 64'(ic_rsp_valid), 64'(vq[i].eirv));
            chk({p, " ic_rd"}, ic_rsp_data,
                vq[i].eirv ? 64'(vq[i].md) : 64'd0);
            chk({p, " dc_rv"}, 64'(dc_rsp_valid), 64'(vq[i].edrv));
            chk({p, " dc_rd"}, dc_rsp_data,
                vq[i].edrv ? 64'(vq[i].md) : 64'd0);
            chk({p, " tag_error"}, 64'(tag_error), 64'(vq[i].eterr));
        end

        // Reset mid-traffic: three outstanding tags are forgotten.
        @(negedge clock);
        drive(0, 1, 0, 0, 4'd1, 4'd0, 64'd0);
        @(negedge clock);
        drive(1, 0, 0, 0, 4'd2, 4'd0, 64'd0);
        #2;
        chk("mid ic_ack", 64'(ic_ack), 64'd1);
        @(negedge clock);
        drive(0, 1, 0, 0, 4'd3, 4'd0, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(1, 1, 0, 1, 4'd4, 4'd1, 64'h5A5A);
        #2;
        chk_quiet("midrst", 1'b0);
        @(negedge clock);
        reset = 1'b1;
        drive(0, 0, 0, 0, 4'd0, 4'd2, 64'h1234);
        #2;
        chk("post ic_rv", 64'(ic_rsp_valid), 64'd0);
        chk("post dc_rv", 64'(dc_rsp_valid), 64'd0);
        chk("post ic_rd", ic_rsp_data, 64'd0);
        chk("post tag_error", 64'(tag_error), 64'd0);
        @(negedge clock);
        drive(0, 0, 0, 0, 4'd0, 4'd0, 64'd0);
        #2;
        chk("post tag_error set", 64'(tag_error), 64'd1);
        chk("post dc_rv idle", 64'(dc_rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
